// File: rtl/vram_painter_if.sv
// vram_painter_if: button/pen inputs and frame-buffer write port of the painter
interface vram_painter_if #(
    parameter int W_BITS = 8,
    parameter int H_BITS = 8
);
    logic btn_up, btn_down, btn_left, btn_right, btn_clr, draw;
    logic [11:0] color;
    logic we, busy;
    logic [W_BITS+H_BITS-1:0] waddr;
    logic [11:0] wdata;
    logic [W_BITS-1:0] cur_x;
    logic [H_BITS-1:0] cur_y;
    modport master (
        input btn_up, btn_down, btn_left, btn_right, btn_clr, draw, color,
        output we, waddr, wdata, cur_x, cur_y, busy
    );
    modport slave (
        output btn_up, btn_down, btn_left, btn_right, btn_clr, draw, color,
        input we, waddr, wdata, cur_x, cur_y, busy
    );
endinterface

// File: rtl/vram_painter.sv
// vram_painter: debounced cursor drawing engine with single-pixel paint and full-canvas clear sweep
module vram_painter #(
    parameter int W_BITS = 8,
    parameter int H_BITS = 8,
    parameter int DEB_CYCLES = 1000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input logic clk,
    input logic rstn,
    vram_painter_if.master bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;
    state_t state;
    logic [4:0] raw, step;
    logic d1, d2, dp;
    logic [W_BITS-1:0] nx;
    logic [H_BITS-1:0] ny;
    logic moved, any_step, draw_rise;
    assign raw = {bus.btn_clr, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    // per button: synchroniser, debouncer, rising-edge step with auto-repeat (none for clr)
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic a, b, lv, pv;
        logic [DW-1:0] dc;
        logic [RW-1:0] rc;
        always_ff @(posedge clk) begin
            if (!rstn) begin
                {a, b, lv, pv} <= '0;
                dc <= '0;
                rc <= '0;
            end else begin
                a <= raw[i];
                b <= a;
                pv <= lv;
                if (b == lv) dc <= '0;
                else if (dc == DW'(DEB_CYCLES - 1)) begin
                    lv <= b;
                    dc <= '0;
                end else dc <= dc + 1'b1;
                rc <= (!lv || step[i]) ? '0 : rc + 1'b1;
            end
        end
        assign step[i] = lv && (!pv || (i != 4 && rc == RW'(REPEAT_CYCLES - 1)));
    end
    assign nx = (step[3] && !step[2] && !(&bus.cur_x)) ? bus.cur_x + 1'b1 :
                (step[2] && !step[3] && |bus.cur_x) ? bus.cur_x - 1'b1 : bus.cur_x;
    assign ny = (step[1] && !step[0] && !(&bus.cur_y)) ? bus.cur_y + 1'b1 :
                (step[0] && !step[1] && |bus.cur_y) ? bus.cur_y - 1'b1 : bus.cur_y;
    assign moved = nx != bus.cur_x || ny != bus.cur_y;
    assign any_step = |step[3:0];
    assign draw_rise = d2 && !dp;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            {d1, d2, dp} <= '0;
            bus.we <= 1'b0;
            bus.busy <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            bus.cur_x <= W_BITS'(1) << (W_BITS - 1);
            bus.cur_y <= H_BITS'(1) << (H_BITS - 1);
        end else begin
            d1 <= bus.draw;
            d2 <= d1;
            dp <= d2;
            case (state)
                IDLE: begin
                    if (step[4]) begin
                        state <= CLEAR;
                        bus.we <= 1'b1;
                        bus.busy <= 1'b1;
                        bus.waddr <= '0;
                        bus.wdata <= CLEAR_COLOR;
                    end else if (moved || (!any_step && draw_rise)) begin
                        bus.cur_x <= nx;
                        bus.cur_y <= ny;
                        // a draw edge coinciding with a move is absorbed into the move's paint
                        if (d2) begin
                            state <= PAINT;
                            bus.we <= 1'b1;
                            bus.waddr <= {ny, nx};
                            bus.wdata <= bus.color;
                        end
                    end
                end
                PAINT: begin
                    state <= IDLE;
                    bus.we <= 1'b0;
                end
                CLEAR: begin
                    if (&bus.waddr) begin
                        state <= IDLE;
                        bus.we <= 1'b0;
                        bus.busy <= 1'b0;
                    end else bus.waddr <= bus.waddr + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_painter.sv
// tb_vram_painter: directed and random stimulus checked every cycle against a behavioural model
module tb_vram_painter;
    localparam int W = 3, H = 3, DEB = 4, REP = 16, N = 1 << (W + H);
    logic clk = 1'b0, rstn = 1'b0;
    logic [5:0] btn = '0;
    logic [11:0] color = '0;
    always #5 clk = ~clk;
    vram_painter_if #(.W_BITS(W), .H_BITS(H)) bus();
    assign bus.btn_up = btn[0];
    assign bus.btn_down = btn[1];
    assign bus.btn_left = btn[2];
    assign bus.btn_right = btn[3];
    assign bus.btn_clr = btn[4];
    assign bus.draw = btn[5];
    assign bus.color = color;
    vram_painter #(.W_BITS(W), .H_BITS(H), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP),
                   .CLEAR_COLOR(12'h000)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    int checks = 0, errors = 0;
    int nwe = 0, last_addr = 0, last_data = 0;
    // model state: raw history per input, debounced level and time held
    bit hist[6][DEB+1];
    bit lvl[5];
    int age[5];
    int mx, my, mmode, mwaddr, mwdata;
    bit mwe, mbusy;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic m_paint();
        mmode = 1;
        mwe = 1;
        mwaddr = my * (1 << W) + mx;
        mwdata = color;
    endtask
    task automatic model_edge();
        bit st[5];
        bit sd, dr, any, flip;
        int tx, ty;
        for (int b = 0; b < 5; b++) st[b] = lvl[b] && (b == 4 ? age[b] == 0 : age[b] % REP == 0);
        sd = hist[5][1];
        dr = hist[5][1] && !hist[5][2];
        if (!rstn) begin
            foreach (hist[b, j]) hist[b][j] = 0;
            for (int b = 0; b < 5; b++) begin lvl[b] = 0; age[b] = 0; end
            mx = 1 << (W - 1); my = 1 << (H - 1);
            mmode = 0; mwe = 0; mbusy = 0; mwaddr = 0; mwdata = 0;
            return;
        end
        if (mmode == 2) begin
            if (mwaddr == N - 1) begin mwe = 0; mbusy = 0; mmode = 0; end
            else mwaddr++;
        end else if (mmode == 1) begin
            mwe = 0; mmode = 0;
        end else if (st[4]) begin
            mmode = 2; mwe = 1; mbusy = 1; mwaddr = 0; mwdata = 0;
        end else begin
            tx = mx + int'(st[3]) - int'(st[2]);
            ty = my + int'(st[1]) - int'(st[0]);
            tx = tx < 0 ? 0 : tx > (1 << W) - 1 ? (1 << W) - 1 : tx;
            ty = ty < 0 ? 0 : ty > (1 << H) - 1 ? (1 << H) - 1 : ty;
            any = st[0] | st[1] | st[2] | st[3];
            if (tx != mx || ty != my) begin
                mx = tx; my = ty;
                if (sd) m_paint();
            end else if (!any && dr) m_paint();
        end
        for (int b = 0; b < 5; b++) begin
            flip = 1;
            for (int j = 1; j <= DEB; j++) if (hist[b][j] == lvl[b]) flip = 0;
            if (flip) begin lvl[b] = !lvl[b]; age[b] = 0; end
            else age[b]++;
        end
        for (int b = 0; b < 6; b++) begin
            for (int j = DEB; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = btn[b];
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("we", bus.we, mwe);
        check("busy", bus.busy, mbusy);
        check("waddr", bus.waddr, mwaddr);
        check("wdata", bus.wdata, mwdata);
        check("cur_x", bus.cur_x, mx);
        check("cur_y", bus.cur_y, my);
        if (bus.we) begin nwe++; last_addr = bus.waddr; last_data = bus.wdata; end
    endtask
    task automatic ticks(int n);
        repeat (n) tick();
    endtask
    task automatic do_reset();
        rstn = 0;
        ticks(2);
        rstn = 1;
    endtask
    initial begin
        int n, idx;
        do_reset();
        check("rst_cur_x", bus.cur_x, 4);
        check("rst_cur_y", bus.cur_y, 4);
        check("rst_we", bus.we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_waddr", bus.waddr, 0);
        // debounce: short glitches, then a stable press released before auto-repeat
        repeat (3) begin
            btn[3] = 1; ticks(3);
            btn[3] = 0; ticks(2);
        end
        ticks(10);
        check("glitch_no_move", bus.cur_x, 4);
        btn[3] = 1;
        n = 0;
        while (bus.cur_x != 5 && n < 20) begin tick(); n++; end
        check("deb_move", bus.cur_x, 5);
        ticks(3);
        btn[3] = 0;
        ticks(30);
        check("deb_no_repeat", bus.cur_x, 5);
        // paint on move and on draw edge
        do_reset();
        color = 12'hF00;
        btn[5] = 1;
        ticks(10);
        nwe = 0;
        btn[3] = 1; ticks(10);
        btn[3] = 0; ticks(20);
        check("paint_count", nwe, 1);
        check("paint_addr", last_addr, 37);
        check("paint_data", last_data, 12'hF00);
        btn[5] = 0; ticks(5);
        nwe = 0;
        btn[5] = 1; ticks(10);
        check("draw_count", nwe, 1);
        check("draw_addr", last_addr, 37);
        // saturation with auto-repeat, then cancelling up+down
        do_reset();
        ticks(10);
        nwe = 0;
        btn[2] = 1; ticks(200);
        check("sat_x", bus.cur_x, 0);
        check("sat_writes", nwe, 4);
        btn[2] = 0; ticks(20);
        nwe = 0;
        btn[0] = 1; btn[1] = 1; ticks(10);
        btn[0] = 0; btn[1] = 0; ticks(20);
        check("cancel_y", bus.cur_y, 4);
        check("cancel_writes", nwe, 0);
        // clear sweep, with a right press that must be discarded
        btn[5] = 0; ticks(5);
        nwe = 0;
        btn[4] = 1;
        n = 0;
        while (!bus.busy && n < 50) begin tick(); n++; end
        check("clr_start", bus.busy, 1);
        btn[4] = 0;
        btn[3] = 1;
        idx = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            check("clr_addr", bus.waddr, idx);
            check("clr_data", bus.wdata, 0);
            idx++;
            if (i == 10) btn[3] = 0;
            tick();
        end
        check("clr_len", idx, 64);
        check("clr_we_count", nwe, 64);
        ticks(20);
        check("clr_keeps_x", bus.cur_x, 0);
        // reset in the middle of a sweep
        btn[4] = 1;
        n = 0;
        while (!(bus.busy && bus.waddr == 20) && n < 200) begin tick(); n++; end
        check("midclr_reached", bus.waddr, 20);
        btn[4] = 0;
        rstn = 0;
        tick();
        check("midclr_we", bus.we, 0);
        check("midclr_busy", bus.busy, 0);
        check("midclr_x", bus.cur_x, 4);
        check("midclr_y", bus.cur_y, 4);
        rstn = 1;
        nwe = 0;
        ticks(80);
        check("midclr_no_writes", nwe, 0);
        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(19) == 0) btn[b] = !btn[b];
            if ($urandom_range(199) == 0) btn[4] = !btn[4];
            if ($urandom_range(29) == 0) btn[5] = !btn[5];
            if ($urandom_range(49) == 0) color = 12'($urandom);
            rstn = $urandom_range(999) != 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
